// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// The optional statistics counters are enabled with MEM_ARB_STATS_EN.
package mem_arb_pkg;

  localparam int unsigned WORD_SIZE_DEF  = 16;
  localparam int unsigned QWORD_SIZE_DEF = 64;
  localparam int unsigned STAT_W         = 16;
  localparam int unsigned STATE_W        = 2;
  localparam int unsigned OP_W           = 2;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [OP_W-1:0]    op_t;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY0   = 2'd1;
  localparam logic [1:0] BUSY1   = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [1:0] OP_NONE    = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_WRITE   = 2'd2;
  localparam logic [1:0] OP_WRITE_Q = 2'd3;

  // One operation per request; read beats quad write beats word write.
  function automatic op_t op_sel(input logic rd, input logic wr, input logic wr_q);
    op_t op;
    op = OP_NONE;
    if (rd) begin
      op = OP_READ;
    end else if (wr_q) begin
      op = OP_WRITE_Q;
    end else if (wr) begin
      op = OP_WRITE;
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin pick between two requesters.
// On a conflict the requester that did not win last time is chosen.
module mem_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between the I-cache (r0) and D-cache (r1) fill engines.
// Define MEM_ARB_STATS_EN to add saturating grant/conflict counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
  parameter int unsigned QWORD_SIZE = QWORD_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  r0_read,
  input  logic                  r0_write,
  input  logic                  r0_write_q,
  input  logic [WORD_SIZE-1:0]  r0_address,
  input  logic [QWORD_SIZE-1:0] r0_wdata,
  output logic [QWORD_SIZE-1:0] r0_rdata,
  output logic                  r0_ack,
  input  logic                  r1_read,
  input  logic                  r1_write,
  input  logic                  r1_write_q,
  input  logic [WORD_SIZE-1:0]  r1_address,
  input  logic [QWORD_SIZE-1:0] r1_wdata,
  output logic [QWORD_SIZE-1:0] r1_rdata,
  output logic                  r1_ack,
  output logic                  m_read,
  output logic                  m_write,
  output logic                  m_write_q,
  output logic [WORD_SIZE-1:0]  m_address,
  output logic [QWORD_SIZE-1:0] m_wdata,
  input  logic [QWORD_SIZE-1:0] m_rdata,
  input  logic                  m_ready,
  input  logic                  m_ack,
  output logic [1:0]            grant
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_grant0,
  output logic [STAT_W-1:0]     stat_grant1,
  output logic [STAT_W-1:0]     stat_conflict
`endif
);

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic [1:0] req;
  logic [1:0] pick;
  op_t        op0;
  op_t        op1;
  op_t        cur_op;
  logic       done0;
  logic       done1;
  logic       conflict;

  assign req[0] = r0_read | r0_write | r0_write_q;
  assign req[1] = r1_read | r1_write | r1_write_q;
  assign op0    = op_sel(r0_read, r0_write, r0_write_q);
  assign op1    = op_sel(r1_read, r1_write, r1_write_q);

  assign done0    = (state == BUSY0) && m_ack;
  assign done1    = (state == BUSY1) && m_ack;
  assign conflict = (state == IDLE) && m_ready && (req == 2'b11);

  mem_arb_rr_pick u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: grant when the port is idle, hold until m_ack, then release
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m_ready && (req != 2'b00)) begin
          state_nxt = pick[0] ? BUSY0 : BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        if (m_ack) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (m_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Port mux: the memory side follows the owner's live request lines
  always_comb begin
    grant     = 2'b00;
    cur_op    = OP_NONE;
    m_address = '0;
    m_wdata   = '0;
    case (state)
      BUSY0: begin
        grant     = 2'b01;
        cur_op    = op0;
        m_address = r0_address;
        m_wdata   = r0_wdata;
      end
      BUSY1: begin
        grant     = 2'b10;
        cur_op    = op1;
        m_address = r1_address;
        m_wdata   = r1_wdata;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

  assign m_read    = (cur_op == OP_READ);
  assign m_write   = (cur_op == OP_WRITE);
  assign m_write_q = (cur_op == OP_WRITE_Q);

  // Completion: one-cycle ack, read data captured only for reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
      last_grant <= 1'b1;
    end else begin
      r0_ack <= done0;
      r1_ack <= done1;
      if (done0 && (op0 == OP_READ)) begin
        r0_rdata <= m_rdata;
      end
      if (done1 && (op1 == OP_READ)) begin
        r1_rdata <= m_rdata;
      end
      if (conflict) begin
        last_grant <= pick[1];
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic issue0;
  logic issue1;

  assign issue0 = (state == IDLE) && (state_nxt == BUSY0);
  assign issue1 = (state == IDLE) && (state_nxt == BUSY1);

  // Saturating event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (issue0 && (stat_grant0 != {STAT_W{1'b1}})) begin
        stat_grant0 <= stat_grant0 + STAT_W'(1);
      end
      if (issue1 && (stat_grant1 != {STAT_W{1'b1}})) begin
        stat_grant1 <= stat_grant1 + STAT_W'(1);
      end
      if (conflict && (stat_conflict != {STAT_W{1'b1}})) begin
        stat_conflict <= stat_conflict + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: memory model, requester model and ack checker
// all advance together on the falling clock edge. Stats checks need MEM_ARB_STATS_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        r0_read = 1'b0, r0_write = 1'b0, r0_write_q = 1'b0;
  logic [15:0] r0_address = '0;
  logic [63:0] r0_wdata = '0;
  logic [63:0] r0_rdata;
  logic        r0_ack;
  logic        r1_read = 1'b0, r1_write = 1'b0, r1_write_q = 1'b0;
  logic [15:0] r1_address = '0;
  logic [63:0] r1_wdata = '0;
  logic [63:0] r1_rdata;
  logic        r1_ack;
  logic        m_read, m_write, m_write_q;
  logic [15:0] m_address;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata = '0;
  logic        m_ready = 1'b1;
  logic        m_ack = 1'b0;
  logic [1:0]  grant;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(16), .QWORD_SIZE(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_read(r0_read), .r0_write(r0_write), .r0_write_q(r0_write_q),
    .r0_address(r0_address), .r0_wdata(r0_wdata), .r0_rdata(r0_rdata), .r0_ack(r0_ack),
    .r1_read(r1_read), .r1_write(r1_write), .r1_write_q(r1_write_q),
    .r1_address(r1_address), .r1_wdata(r1_wdata), .r1_rdata(r1_rdata), .r1_ack(r1_ack),
    .m_read(m_read), .m_write(m_write), .m_write_q(m_write_q),
    .m_address(m_address), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_ready(m_ready), .m_ack(m_ack), .grant(grant)
`ifdef MEM_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  typedef struct packed {
    logic [1:0]  grant;
    logic [2:0]  strb;   // {m_read, m_write, m_write_q}
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } mem_exp_t;

  typedef struct packed {
    logic [1:0]  who;
    logic [63:0] rd0;
    logic [63:0] rd1;
  } ack_exp_t;

  mem_exp_t    exp_mem[$];
  ack_exp_t    exp_ack[$];
  mem_exp_t    cur;
  logic [63:0] mdl_rd0 = '0, mdl_rd1 = '0;
  int          n_tests = 0, n_fail = 0;
  logic        mem_block = 1'b0;
  logic        mem_busy = 1'b0;
  int          mem_lat = 3;
  int          mem_cnt = 0;
  logic        prev_ack0 = 1'b0, prev_ack1 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // rwq = {read, write, write_q}
  task automatic push_txn(input int id, input logic [2:0] rwq, input logic [15:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata);
    mem_exp_t m;
    ack_exp_t a;
    m.grant = (id == 0) ? 2'b01 : 2'b10;
    if (rwq[2])      m.strb = 3'b100;
    else if (rwq[0]) m.strb = 3'b001;
    else             m.strb = 3'b010;
    m.addr  = addr;
    m.wdata = wdata;
    m.rdata = rdata;
    if (rwq[2]) begin
      if (id == 0) mdl_rd0 = rdata;
      else         mdl_rd1 = rdata;
    end
    a.who = m.grant;
    a.rd0 = mdl_rd0;
    a.rd1 = mdl_rd1;
    exp_mem.push_back(m);
    exp_ack.push_back(a);
  endtask

  task automatic drive_req(input int id, input logic [2:0] rwq, input logic [15:0] addr,
                           input logic [63:0] wdata);
    if (id == 0) begin
      {r0_read, r0_write, r0_write_q} = rwq;
      r0_address = addr;
      r0_wdata   = wdata;
    end else begin
      {r1_read, r1_write, r1_write_q} = rwq;
      r1_address = addr;
      r1_wdata   = wdata;
    end
  endtask

  task automatic mem_step();
    if (!reset_n) begin
      mem_busy = 1'b0;
      m_ack    = 1'b0;
      m_rdata  = '0;
      m_ready  = 1'b1;
    end else begin
      if (m_ack) begin
        check("ack_latency", {r1_ack, r0_ack}, cur.grant);
        m_ack    = 1'b0;
        m_rdata  = '0;
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt <= 0) begin
          m_ack   = 1'b1;
          m_rdata = cur.rdata;
        end
      end else if (m_read | m_write | m_write_q) begin
        if (exp_mem.size() == 0) begin
          check("mem_unexpected", {m_read, m_write, m_write_q}, 3'b000);
        end else begin
          cur = exp_mem.pop_front();
          check("mem_grant", grant, cur.grant);
          check("mem_strobe", {m_read, m_write, m_write_q}, cur.strb);
          check("mem_addr", m_address, cur.addr);
          check("mem_wdata", m_wdata, cur.wdata);
          mem_busy = 1'b1;
          mem_cnt  = mem_lat;
        end
      end
      m_ready = !mem_busy && !mem_block;
    end
  endtask

  task automatic ack_step();
    ack_exp_t a;
    if (reset_n) begin
      if (prev_ack0) check("r0_ack_pulse", r0_ack, 1'b0);
      if (prev_ack1) check("r1_ack_pulse", r1_ack, 1'b0);
      if (r0_ack | r1_ack) begin
        if (exp_ack.size() == 0) begin
          check("ack_unexpected", {r1_ack, r0_ack}, 2'b00);
        end else begin
          a = exp_ack.pop_front();
          check("ack_who", {r1_ack, r0_ack}, a.who);
          check("r0_rdata", r0_rdata, a.rd0);
          check("r1_rdata", r1_rdata, a.rd1);
          check("release_grant", grant, 2'b00);
          check("release_strobe", {m_read, m_write, m_write_q}, 3'b000);
        end
        if (r0_ack) {r0_read, r0_write, r0_write_q} = 3'b000;
        if (r1_ack) {r1_read, r1_write, r1_write_q} = 3'b000;
      end
    end
    prev_ack0 = r0_ack;
    prev_ack1 = r1_ack;
  endtask

  task automatic tick();
    @(negedge clk);
    mem_step();
    ack_step();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_ack.size() != 0 || exp_mem.size() != 0 || mem_busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("timeout", 1'b1, 1'b0);
    tick();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_grant"}, grant, 2'b00);
    check({pfx, "_strobe"}, {m_read, m_write, m_write_q}, 3'b000);
    check({pfx, "_maddr"}, m_address, 16'h0);
    check({pfx, "_mwdata"}, m_wdata, 64'h0);
    check({pfx, "_acks"}, {r1_ack, r0_ack}, 2'b00);
    check({pfx, "_r0_rdata"}, r0_rdata, 64'h0);
    check({pfx, "_r1_rdata"}, r1_rdata, 64'h0);
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    #1;
    check_all_zero("reset");
    drive_req(0, 3'b000, 16'h0, 64'h0);
    drive_req(1, 3'b000, 16'h0, 64'h0);
    exp_mem.delete();
    exp_ack.delete();
    mdl_rd0 = '0;
    mdl_rd1 = '0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    #2;
    hard_reset();

    // Solo read with a 6-cycle memory
    mem_lat = 6;
    push_txn(0, 3'b100, 16'h0023, 64'h0, 64'h6100_f01c_6000_0000);
    drive_req(0, 3'b100, 16'h0023, 64'h0);
    tick();
    check("t1_grant", grant, 2'b01);
    check("t1_m_read", m_read, 1'b1);
    check("t1_m_address", m_address, 16'h0023);
    wait_done(40);
    mem_lat = 3;

    // First conflict after reset: r0 wins, then r1 quad write
    push_txn(0, 3'b100, 16'h0100, 64'h0, 64'hAAAA_0000_1111_2222);
    push_txn(1, 3'b001, 16'h0200, 64'hDEAD_BEEF_0BAD_F00D, 64'h0);
    drive_req(0, 3'b100, 16'h0100, 64'h0);
    drive_req(1, 3'b001, 16'h0200, 64'hDEAD_BEEF_0BAD_F00D);
    wait_done(60);

    // Next conflict alternates: r1 first
    push_txn(1, 3'b100, 16'h0300, 64'h0, 64'h1357_9BDF_2468_ACE0);
    push_txn(0, 3'b010, 16'h0400, 64'h0000_0000_0000_5A5A, 64'h0);
    drive_req(0, 3'b010, 16'h0400, 64'h0000_0000_0000_5A5A);
    drive_req(1, 3'b100, 16'h0300, 64'h0);
    wait_done(60);

    // Memory not ready: no strobe until m_ready returns
    mem_block = 1'b1;
    tick();
    push_txn(1, 3'b010, 16'h0001, 64'h0000_0000_0000_1234, 64'h0);
    drive_req(1, 3'b010, 16'h0001, 64'h0000_0000_0000_1234);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("notready_grant", grant, 2'b00);
      check("notready_m_write", m_write, 1'b0);
    end
    mem_block = 1'b0;
    wait_done(40);

    // Read and write together: only the read is forwarded
    push_txn(0, 3'b110, 16'h0055, 64'h0, 64'hCAFE_F00D_0000_0077);
    drive_req(0, 3'b110, 16'h0055, 64'h0);
    wait_done(40);

    // Reset in the middle of a BUSY1 read
    mem_lat = 6;
    push_txn(1, 3'b100, 16'h0666, 64'h0, 64'h9999_8888_7777_6666);
    drive_req(1, 3'b100, 16'h0666, 64'h0);
    n = 0;
    while (grant != 2'b10 && n < 10) begin
      tick();
      n++;
    end
    check("busy1_reached", grant, 2'b10);
    tick();
    tick();
    hard_reset();
    for (int i = 0; i < 4; i++) tick();
    mem_lat = 3;
    push_txn(0, 3'b100, 16'h0777, 64'h0, 64'h0123_4567_89AB_CDEF);
    push_txn(1, 3'b010, 16'h0888, 64'h0000_0000_0000_4321, 64'h0);
    drive_req(0, 3'b100, 16'h0777, 64'h0);
    drive_req(1, 3'b010, 16'h0888, 64'h0000_0000_0000_4321);
    wait_done(60);

`ifdef MEM_ARB_STATS_EN
    hard_reset();
    check("stat_grant0_rst", stat_grant0, 16'd0);
    check("stat_grant1_rst", stat_grant1, 16'd0);
    check("stat_conflict_rst", stat_conflict, 16'd0);
    for (int k = 0; k < 3; k++) begin
      logic [63:0] rd;
      rd = 64'h5000_0000_0000_0000 + 64'(k);
      if (k % 2 == 0) begin
        push_txn(0, 3'b100, 16'h1000 + 16'(k), 64'h0, rd);
        push_txn(1, 3'b001, 16'h2000 + 16'(k), 64'hF0F0_0000_0000_0000 + 64'(k), 64'h0);
      end else begin
        push_txn(1, 3'b001, 16'h2000 + 16'(k), 64'hF0F0_0000_0000_0000 + 64'(k), 64'h0);
        push_txn(0, 3'b100, 16'h1000 + 16'(k), 64'h0, rd);
      end
      drive_req(0, 3'b100, 16'h1000 + 16'(k), 64'h0);
      drive_req(1, 3'b001, 16'h2000 + 16'(k), 64'hF0F0_0000_0000_0000 + 64'(k));
      wait_done(60);
    end
    for (int k = 0; k < 2; k++) begin
      push_txn(0, 3'b010, 16'h3000 + 16'(k), 64'h0000_0000_0000_0AB0 + 64'(k), 64'h0);
      drive_req(0, 3'b010, 16'h3000 + 16'(k), 64'h0000_0000_0000_0AB0 + 64'(k));
      wait_done(40);
    end
    check("stat_grant0", stat_grant0, 16'd5);
    check("stat_grant1", stat_grant1, 16'd3);
    check("stat_conflict", stat_conflict, 16'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
